// File: rtl/soc_bram_arb_if.sv
// soc_bram_arb_if: valid/ready request bus shared by the CPU ports and the BRAM controller side.
// master drives the request fields; slave returns the completion pulse and read data.
interface soc_bram_arb_if #(parameter int addr_width = 8);
    logic [addr_width-1:0] addr;
    logic                  rw;
    logic [31:0]           dwrite;
    logic                  valid;
    logic                  ready;
    logic [31:0]           dread;
    modport master (output addr, rw, dwrite, valid, input ready, dread);
    modport slave (input addr, rw, dwrite, valid, output ready, dread);
endinterface

// File: rtl/soc_bram_arb.sv
// soc_bram_arb: two-master round-robin arbiter in front of soc_bram_ctl, fully registered outputs.
// Optional watchdog enabled by defining SOC_BRAM_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module soc_bram_arb #(
    parameter int addr_width = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                resetn,
    soc_bram_arb_if.slave       m0,
    soc_bram_arb_if.slave       m1,
    soc_bram_arb_if.master      s,
    output logic                err
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [31:0]           dwrite_q, dwrite_d;
    logic                  valid_q, valid_d;
    logic                  r0_q, r0_d, r1_q, r1_d;
    logic [31:0]           d0_q, d0_d, d1_q, d1_d;
    logic                  e0, e1, g1, b1, done;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
    localparam int tw = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [tw-1:0] timer_q, timer_d;
    logic          err_q, err_d, expired;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
    assign s.addr    = addr_q;
    assign s.rw      = rw_q;
    assign s.dwrite  = dwrite_q;
    assign s.valid   = valid_q;
    assign m0.ready  = r0_q;
    assign m0.dread  = d0_q;
    assign m1.ready  = r1_q;
    assign m1.dread  = d1_q;
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        rw_d     = rw_q;
        dwrite_d = dwrite_q;
        valid_d  = valid_q;
        r0_d     = 1'b0;
        r1_d     = 1'b0;
        d0_d     = d0_q;
        d1_d     = d1_q;
        // a master whose ready pulse is out this cycle cannot start again yet
        e0       = m0.valid && !r0_q;
        e1       = m1.valid && !r1_q;
        g1       = e1 && (!e0 || !last_q);
        b1       = state_q == BUSY1;
        done     = 1'b0;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
        timer_d  = timer_q;
        err_d    = 1'b0;
        expired  = 1'b0;
`endif
        if (state_q == IDLE) begin
            if (e0 || e1) begin
                addr_d   = g1 ? m1.addr : m0.addr;
                rw_d     = g1 ? m1.rw : m0.rw;
                dwrite_d = g1 ? m1.dwrite : m0.dwrite;
                valid_d  = 1'b1;
                last_d   = g1;
                state_d  = g1 ? BUSY1 : BUSY0;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
                timer_d  = '0;
`endif
            end
        end else begin
            done = s.ready;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
            expired = !s.ready && (timer_q == tw'(TIMEOUT - 1));
            timer_d = s.ready ? timer_q : timer_q + 1'b1;
            err_d   = expired;
            done    = s.ready || expired;
`endif
            if (done) begin
                valid_d = 1'b0;
                r0_d    = !b1;
                r1_d    = b1;
                d0_d    = (!b1 && s.ready && !rw_q) ? s.dread : d0_q;
                d1_d    = (b1 && s.ready && !rw_q) ? s.dread : d1_q;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            dwrite_q <= '0;
            valid_q  <= 1'b0;
            r0_q     <= 1'b0;
            r1_q     <= 1'b0;
            d0_q     <= '0;
            d1_q     <= '0;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
            timer_q  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            dwrite_q <= dwrite_d;
            valid_q  <= valid_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
            timer_q  <= timer_d;
            err_q    <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_soc_bram_arb.sv
// tb_soc_bram_arb: directed checks of grant order, data return, async reset and the optional watchdog.
module tb_soc_bram_arb;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic err;
    int   n_chk = 0;
    int   n_fail = 0;
    soc_bram_arb_if #(.addr_width(8)) m0 ();
    soc_bram_arb_if #(.addr_width(8)) m1 ();
    soc_bram_arb_if #(.addr_width(8)) s ();
    soc_bram_arb #(.addr_width(8), .TIMEOUT(4)) dut (
        .clk(clk), .resetn(resetn), .m0(m0.slave), .m1(m1.slave), .s(s.master), .err(err)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(negedge clk);
    endtask
    initial begin
        {m0.addr, m0.rw, m0.dwrite, m0.valid} = '0;
        {m1.addr, m1.rw, m1.dwrite, m1.valid} = '0;
        s.ready = 1'b0;
        s.dread = '0;
        cyc();
        chk("rst_s_valid", 32'(s.valid), 0);
        chk("rst_s_addr", 32'(s.addr), 0);
        chk("rst_s_rw", 32'(s.rw), 0);
        chk("rst_s_dwrite", s.dwrite, 0);
        chk("rst_m0_ready", 32'(m0.ready), 0);
        chk("rst_m1_ready", 32'(m1.ready), 0);
        chk("rst_m0_dread", m0.dread, 0);
        chk("rst_m1_dread", m1.dread, 0);
        chk("rst_err", 32'(err), 0);
        resetn = 1'b1;
        cyc();
        // m0 write, completion two cycles after s_valid rises
        m0.addr = 8'd32; m0.rw = 1'b1; m0.dwrite = 32'h11223344; m0.valid = 1'b1;
        #1 chk("t1_latency", 32'(s.valid), 0);
        cyc();
        chk("t1_s_valid", 32'(s.valid), 1);
        chk("t1_s_addr", 32'(s.addr), 32);
        chk("t1_s_rw", 32'(s.rw), 1);
        chk("t1_s_dwrite", s.dwrite, 32'h11223344);
        chk("t1_m0_ready_early", 32'(m0.ready), 0);
        cyc();
        chk("t1_s_valid_hold", 32'(s.valid), 1);
        s.ready = 1'b1;
        cyc();
        chk("t1_m0_ready", 32'(m0.ready), 1);
        chk("t1_m1_ready", 32'(m1.ready), 0);
        chk("t1_s_valid_drop", 32'(s.valid), 0);
        chk("t1_err", 32'(err), 0);
        m0.valid = 1'b0; s.ready = 1'b0;
        cyc();
        chk("t1_m0_ready_pulse", 32'(m0.ready), 0);
        chk("t1_s_valid_idle", 32'(s.valid), 0);
        // m1 read returns data only to m1
        m1.addr = 8'd36; m1.rw = 1'b0; m1.valid = 1'b1;
        cyc();
        chk("t2_s_valid", 32'(s.valid), 1);
        chk("t2_s_addr", 32'(s.addr), 36);
        chk("t2_s_rw", 32'(s.rw), 0);
        s.ready = 1'b1; s.dread = 32'h55667788;
        cyc();
        chk("t2_m1_ready", 32'(m1.ready), 1);
        chk("t2_m1_dread", m1.dread, 32'h55667788);
        chk("t2_m0_ready", 32'(m0.ready), 0);
        chk("t2_m0_dread", m0.dread, 0);
        m1.valid = 1'b0; s.ready = 1'b0;
        cyc();
        chk("t2_m1_ready_pulse", 32'(m1.ready), 0);
        chk("t2_m1_dread_hold", m1.dread, 32'h55667788);
        // stray s_ready while idle
        s.ready = 1'b1; s.dread = 32'hdeadbeef;
        cyc();
        chk("t5_s_valid", 32'(s.valid), 0);
        chk("t5_m0_ready", 32'(m0.ready), 0);
        chk("t5_m1_ready", 32'(m1.ready), 0);
        chk("t5_m1_dread", m1.dread, 32'h55667788);
        s.ready = 1'b0;
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        // contention from reset with s_ready held: m0, m1, m0, m1
        m0.addr = 8'h10; m0.rw = 1'b1; m0.dwrite = 32'h0badf00d; m0.valid = 1'b1;
        m1.addr = 8'h20; m1.rw = 1'b0; m1.valid = 1'b1;
        s.ready = 1'b1; s.dread = 32'ha5a5a5a5;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k % 2 == 1) begin
                chk($sformatf("t3_s_valid_%0d", k), 32'(s.valid), 1);
                chk($sformatf("t3_s_addr_%0d", k), 32'(s.addr), (k % 4 == 1) ? 32'h10 : 32'h20);
            end else begin
                chk($sformatf("t3_s_valid_%0d", k), 32'(s.valid), 0);
                chk($sformatf("t3_m0_ready_%0d", k), 32'(m0.ready), (k % 4 == 2) ? 1 : 0);
                chk($sformatf("t3_m1_ready_%0d", k), 32'(m1.ready), (k % 4 == 0) ? 1 : 0);
            end
        end
        m0.valid = 1'b0; m1.valid = 1'b0; s.ready = 1'b0;
        cyc();
        chk("t3_no_double_issue", 32'(s.valid), 0);
        chk("t3_m1_dread", m1.dread, 32'ha5a5a5a5);
        chk("t3_m0_dread", m0.dread, 0);
        // async reset while BUSY1 discards the transaction
        m1.addr = 8'h30; m1.rw = 1'b0; m1.valid = 1'b1;
        cyc();
        chk("t4_s_valid", 32'(s.valid), 1);
        #2 resetn = 1'b0;
        #1 chk("t4_async_s_valid", 32'(s.valid), 0);
        m1.valid = 1'b0; s.ready = 1'b1;
        cyc();
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("t4_m1_ready_%0d", k), 32'(m1.ready), 0);
            chk($sformatf("t4_s_valid_idle_%0d", k), 32'(s.valid), 0);
        end
        m0.addr = 8'h40; m0.rw = 1'b0; m0.valid = 1'b1; s.dread = 32'h12345678;
        cyc();
        chk("t4_next_s_valid", 32'(s.valid), 1);
        chk("t4_next_s_addr", 32'(s.addr), 32'h40);
        cyc();
        chk("t4_next_m0_ready", 32'(m0.ready), 1);
        chk("t4_next_m0_dread", m0.dread, 32'h12345678);
        m0.valid = 1'b0; s.ready = 1'b0;
        cyc();
        // stalled controller: watchdog when enabled, indefinite wait otherwise
        m0.addr = 8'h44; m0.rw = 1'b0; m0.valid = 1'b1; s.dread = 32'hcafef00d;
`ifdef SOC_BRAM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("t6_s_valid_%0d", k), 32'(s.valid), 1);
            chk($sformatf("t6_m0_ready_%0d", k), 32'(m0.ready), 0);
            chk($sformatf("t6_err_%0d", k), 32'(err), 0);
        end
        m0.valid = 1'b0;
        cyc();
        chk("t6_timeout_s_valid", 32'(s.valid), 0);
        chk("t6_timeout_m0_ready", 32'(m0.ready), 1);
        chk("t6_timeout_err", 32'(err), 1);
        chk("t6_timeout_m0_dread", m0.dread, 32'h12345678);
        cyc();
        chk("t6_err_pulse", 32'(err), 0);
        chk("t6_m0_ready_pulse", 32'(m0.ready), 0);
`else
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("t6_s_valid_%0d", k), 32'(s.valid), 1);
            chk($sformatf("t6_m0_ready_%0d", k), 32'(m0.ready), 0);
            chk($sformatf("t6_err_%0d", k), 32'(err), 0);
        end
        s.ready = 1'b1;
        cyc();
        chk("t6_m0_ready", 32'(m0.ready), 1);
        chk("t6_m0_dread", m0.dread, 32'hcafef00d);
        chk("t6_err", 32'(err), 0);
        m0.valid = 1'b0; s.ready = 1'b0;
        cyc();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
